alu_control_seq: RTL
====================

Name: alu_control_seq

Overview:
- Parametrised, registered successor to the combinational ALU control decoder in the multicycle datapath.
- Accepts a decode request (ALUOp + funct) on a valid/ready handshake and drives a registered alu_control code to the ALU.
- Holds that code for a per-operation number of cycles: 1 for simple ops, MUL_CYCLES for multiply.
- Flags illegal funct codes and supports an abort from the main control FSM.

Parameters:
- OP_W, 2, ALUOp width
- FUNC_W, 6, funct field width
- CTRL_W, 4, alu_control width (must be >= 4)
- MUL_EN, 1, 1 = multiply funct decoded as a multicycle op; 0 = multiply is illegal
- MUL_CYCLES, 4, cycles the multiply code is held (must be >= 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  decode request present
- req_ready  out  1  block can accept a request this cycle
- op  in  OP_W  ALUOp from main control
- func  in  FUNC_W  instruction funct field
- abort  in  1  synchronous cancel of the operation in flight
- alu_control  out  CTRL_W  registered ALU operation code
- ctrl_valid  out  1  alu_control is meaningful this cycle
- busy  out  1  a multicycle op is in progress
- done  out  1  single-cycle pulse on the last cycle of an op
- illegal  out  1  registered; high for the op's cycle when the accepted request was undecodable

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, alu_control=4'b0010 (ADD), ctrl_valid=0, busy=0, done=0, illegal=0, counter=0. req_ready=1 from the first cycle after reset.
- Decode table (upper CTRL_W-4 bits are zero):
  - op=00 -> 0010 ADD; op=01 -> 0110 SUB; op=11 -> illegal.
  - op=10, func: 100000 ADD 0010; 100010 SUB 0110; 100100 AND 0000; 100101 OR 0001; 100110 XOR 0011; 100111 NOR 1100; 101010 SLT 0111; 000000 SLL 1001; 000010 SRL 1010; 011000 MUL 1000 (multicycle if MUL_EN=1, else illegal).
  - Any other func -> illegal.
  - Illegal requests drive alu_control=1111 (NOP), illegal=1, and are single-cycle.
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - op and func are sampled only at acceptance; later changes are ignored.
  - req_ready = (state==IDLE) || (last cycle of current op && !abort).
- FSM states:
  - IDLE: ctrl_valid=0. On accept, go to SINGLE or MULTI.
  - SINGLE: ctrl_valid=1 and done=1 for exactly one cycle. Then go to IDLE, or straight to a new op if one is accepted that cycle.
  - MULTI: ctrl_valid=1 and busy=1 for MUL_CYCLES consecutive cycles. The counter loads MUL_CYCLES-1 and decrements. done=1 when counter==0. Then go to IDLE or a new op as above.
- Latency: request accepted at edge N -> alu_control/ctrl_valid valid in cycle N+1.
  - Single op: done in N+1.
  - MUL: done in N+MUL_CYCLES.
- Throughput: back-to-back requests give gap-free ctrl_valid.
- Boundary conditions:
  - alu_control is held stable throughout a MULTI op.
  - abort has priority over everything except reset. Next state is IDLE; ctrl_valid, busy and done are 0 next cycle; alu_control keeps its value. A request presented in the same cycle as abort is not accepted (req_ready=0).
  - reset during MULTI: all outputs return to reset values next cycle; no done pulse.
  - req_valid held high in IDLE with an illegal code: one illegal single-cycle op per accepted request.

Decomposition:
- Shared package alu_pkg holds:
  - ALUOp constants: ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10.
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLL, F_SRL, F_MUL.
  - alu_control code constants: ALU_AND…ALU_NOP.
  - FSM state encoding.
- One sub-module, alu_decode: purely combinational (op, func) -> {code, is_multi, illegal}. The FSM and counter stay in alu_control_seq.

Test Plan:
1. Reset mid-MUL: accept MUL, assert reset on its 2nd cycle -> next cycle alu_control=0010, ctrl_valid=0, busy=0; no done pulse.
2. Decode sweep: each legal (op, func) pair as single requests -> alu_control matches the table one cycle after accept; done=1 with ctrl_valid; illegal=0.
3. Illegal codes: op=10 func=101111, and op=11 -> alu_control=1111, illegal=1 for one cycle, done=1.
4. MUL with MUL_CYCLES=4: accept at edge N -> alu_control=1000, busy=1 in cycles N+1..N+4; done only in N+4; req_ready=0 in N+1..N+3 and 1 in N+4.
5. Back-to-back: ADD, SUB, MUL, AND with req_valid held -> ctrl_valid continuous for 7 cycles; codes 0010, 0110, 1000×4, 0000.
6. Abort: abort on the 3rd MUL cycle with req_valid=1 -> next cycle IDLE, ctrl_valid=0; the pending request is accepted one cycle later. Also, with MUL_EN=0, func=011000 -> illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALUOp / funct / alu_control encodings and FSM states
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_MUL = 6'b011000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SINGLE = 2'b01,
        ST_MULTI  = 2'b10
    } state_e;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_decode.sv
// ============================================================================
// Module      : alu_decode
// Description : Combinational (ALUOp, funct) -> {alu code, multicycle, illegal}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode
    import alu_pkg::*;
#(
    parameter int unsigned OP_W   = 2,
    parameter int unsigned FUNC_W = 6,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned MUL_EN = 1
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [FUNC_W-1:0] func_i,
    output logic [CTRL_W-1:0] code_o,
    output logic              is_multi_o,
    output logic              illegal_o
);

    logic [3:0] w_code4;
    logic       w_multi;
    logic       w_illegal;

    always_comb begin
        w_code4   = ALU_NOP;
        w_multi   = 1'b0;
        w_illegal = 1'b1;
        if (op_i == OP_W'(ALUOP_ADD)) begin
            w_code4   = ALU_ADD;
            w_illegal = 1'b0;
        end else if (op_i == OP_W'(ALUOP_SUB)) begin
            w_code4   = ALU_SUB;
            w_illegal = 1'b0;
        end else if (op_i == OP_W'(ALUOP_RTYPE)) begin
            w_illegal = 1'b0;
            case (func_i)
                FUNC_W'(F_ADD): w_code4 = ALU_ADD;
                FUNC_W'(F_SUB): w_code4 = ALU_SUB;
                FUNC_W'(F_AND): w_code4 = ALU_AND;
                FUNC_W'(F_OR):  w_code4 = ALU_OR;
                FUNC_W'(F_XOR): w_code4 = ALU_XOR;
                FUNC_W'(F_NOR): w_code4 = ALU_NOR;
                FUNC_W'(F_SLT): w_code4 = ALU_SLT;
                FUNC_W'(F_SLL): w_code4 = ALU_SLL;
                FUNC_W'(F_SRL): w_code4 = ALU_SRL;
                FUNC_W'(F_MUL): begin
                    // Without a multiplier the MUL funct falls back to NOP/illegal
                    if (MUL_EN != 0) begin
                        w_code4 = ALU_MUL;
                        w_multi = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                default: w_illegal = 1'b1;
            endcase
        end
    end

    assign code_o     = CTRL_W'(w_code4);
    assign is_multi_o = w_multi;
    assign illegal_o  = w_illegal;

endmodule : alu_decode

`default_nettype wire

// File: rtl/alu_control_seq.sv
// ============================================================================
// Module      : alu_control_seq
// Description : Registered ALU control sequencer with valid/ready request,
//               multicycle MUL hold, illegal flagging and abort
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control_seq
    import alu_pkg::*;
#(
    parameter int unsigned OP_W       = 2,
    parameter int unsigned FUNC_W     = 6,
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_EN     = 1,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [FUNC_W-1:0] func,
    input  logic              abort,
    output logic [CTRL_W-1:0] alu_control,
    output logic              ctrl_valid,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    localparam int unsigned     CNT_W    = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   code_q, code_d;
    logic                illegal_q, illegal_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [CTRL_W-1:0]   w_dec_code;
    logic                w_dec_multi;
    logic                w_dec_illegal;
    logic                w_last;
    logic                w_accept;

    alu_decode #(
        .OP_W   (OP_W),
        .FUNC_W (FUNC_W),
        .CTRL_W (CTRL_W),
        .MUL_EN (MUL_EN)
    ) u_decode (
        .op_i       (op),
        .func_i     (func),
        .code_o     (w_dec_code),
        .is_multi_o (w_dec_multi),
        .illegal_o  (w_dec_illegal)
    );

    // The final cycle of an op doubles as an accept slot, giving gap-free issue
    assign w_last    = (state_q == ST_SINGLE) ||
                       ((state_q == ST_MULTI) && (cnt_q == '0));
    assign req_ready = !abort && ((state_q == ST_IDLE) || w_last);
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (abort) begin
            // alu_control deliberately keeps its last value on abort
            state_d   = ST_IDLE;
            illegal_d = 1'b0;
            cnt_d     = '0;
        end else if (w_accept) begin
            code_d    = w_dec_code;
            illegal_d = w_dec_illegal;
            if (w_dec_multi) begin
                state_d = ST_MULTI;
                cnt_d   = CNT_LOAD;
            end else begin
                state_d = ST_SINGLE;
                cnt_d   = '0;
            end
        end else if (w_last) begin
            state_d   = ST_IDLE;
            illegal_d = 1'b0;
        end else if (state_q == ST_MULTI) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            code_q    <= CTRL_W'(ALU_ADD);
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign alu_control = code_q;
    assign ctrl_valid  = (state_q != ST_IDLE);
    assign busy        = (state_q == ST_MULTI);
    assign done        = w_last;
    assign illegal     = illegal_q;

endmodule : alu_control_seq

`default_nettype wire
